// File: rtl/tlul_host_bridge.sv
// TL-UL initiator bridge: req/gnt/rvalid host port to TL-UL A/D channels.
// Optional d_source check against issue order: define TLUL_HOST_SRCCHK_EN.
module tlul_host_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [7:0]  SOURCE_BASE     = 8'h00,
  localparam int TL_AW  = 32,
  localparam int TL_DW  = 32,
  localparam int TL_AIW = 8,
  localparam int TL_AUW = 16,
  localparam int TL_DBW = 4,
  localparam int TL_SZW = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [TL_AW-1:0]  addr_i,
  input  logic              we_i,
  input  logic [TL_DW-1:0]  wdata_i,
  input  logic [TL_DBW-1:0] be_i,
  output logic              rvalid_o,
  output logic [TL_DW-1:0]  rdata_o,
  output logic              err_o,
  output logic              tl_a_valid_o,
  output logic [2:0]        tl_a_opcode_o,
  output logic [2:0]        tl_a_param_o,
  output logic [TL_SZW-1:0] tl_a_size_o,
  output logic [TL_AIW-1:0] tl_a_source_o,
  output logic [TL_AW-1:0]  tl_a_address_o,
  output logic [TL_DBW-1:0] tl_a_mask_o,
  output logic [TL_DW-1:0]  tl_a_data_o,
  output logic [TL_AUW-1:0] tl_a_user_o,
  input  logic              tl_a_ready_i,
  input  logic              tl_d_valid_i,
  input  logic [2:0]        tl_d_opcode_i,
  input  logic [TL_AIW-1:0] tl_d_source_i,
  input  logic [TL_DW-1:0]  tl_d_data_i,
  input  logic              tl_d_error_i,
  output logic              tl_d_ready_o
);

  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PART = 3'd1;
  localparam logic [2:0] GET      = 3'd4;
  localparam logic [2:0] ACK      = 3'd0;
  localparam logic [2:0] ACK_DATA = 3'd1;

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [PW-1:0] PTR_MAX = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] issue_ptr_q, retire_ptr_q;
  logic          space;
  logic          stray;
  logic          retire;
  logic          op_bad;
  logic          resp_err;
  logic          unused_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  // Space uses the registered count, so a retire never frees a slot early.
  assign space        = cnt_q < CNT_MAX;
  assign tl_a_valid_o = rst_ni & req_i & space;
  assign gnt_o        = tl_a_valid_o & tl_a_ready_i;
  assign tl_d_ready_o = 1'b1;

  always_comb begin
    tl_a_opcode_o = PUT_PART;
    unique case (1'b1)
      !we_i:                  tl_a_opcode_o = GET;
      we_i && be_i == 4'hF:   tl_a_opcode_o = PUT_FULL;
      we_i && be_i != 4'hF:   tl_a_opcode_o = PUT_PART;
      default:                tl_a_opcode_o = PUT_PART;
    endcase
  end

  assign tl_a_param_o   = 3'd0;
  assign tl_a_size_o    = TL_SZW'(2);
  assign tl_a_user_o    = '0;
  assign tl_a_source_o  = SOURCE_BASE + TL_AIW'(issue_ptr_q);
  assign tl_a_address_o = {addr_i[TL_AW-1:2], 2'b00};
  assign tl_a_mask_o    = we_i ? be_i : 4'hF;
  assign tl_a_data_o    = we_i ? wdata_i : '0;

  assign stray  = tl_d_valid_i & (cnt_q == '0);
  assign retire = tl_d_valid_i & ~stray;
  assign op_bad = (tl_d_opcode_i != ACK) &&
                  (tl_d_opcode_i != ACK_DATA);

`ifdef TLUL_HOST_SRCCHK_EN
  logic src_bad;
  logic src_sticky_q;
  logic unused_sticky;

  assign src_bad  = tl_d_source_i != (SOURCE_BASE + TL_AIW'(retire_ptr_q));
  assign resp_err = tl_d_error_i | op_bad | stray | src_bad;
  assign unused_sticky = src_sticky_q;
  assign unused_bits   = ^addr_i[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_sticky_q <= 1'b0;
    end else if (tl_d_valid_i && src_bad) begin
      src_sticky_q <= 1'b1;
    end
  end
`else
  assign resp_err    = tl_d_error_i | op_bad | stray;
  assign unused_bits = ^{addr_i[1:0], tl_d_source_i};
`endif

  always_comb begin
    cnt_d = cnt_q;
    unique case ({gnt_o, retire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      issue_ptr_q  <= '0;
      retire_ptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (gnt_o) issue_ptr_q <= ptr_inc(issue_ptr_q);
      if (retire) retire_ptr_q <= ptr_inc(retire_ptr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= tl_d_valid_i;
      if (tl_d_valid_i) begin
        rdata_o <= (tl_d_opcode_i == ACK_DATA) ? tl_d_data_i : '0;
        err_o   <= resp_err;
      end
    end
  end

endmodule

// File: tb/tb_tlul_host_bridge.sv
// Directed testbench for tlul_host_bridge (MAX_OUTSTANDING=2, SOURCE_BASE=0).
// Source-check expectations follow TLUL_HOST_SRCCHK_EN.
module tb_tlul_host_bridge;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i, gnt_o, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic        tl_a_valid_o;
  logic [2:0]  tl_a_opcode_o, tl_a_param_o;
  logic [1:0]  tl_a_size_o;
  logic [7:0]  tl_a_source_o;
  logic [31:0] tl_a_address_o, tl_a_data_o;
  logic [3:0]  tl_a_mask_o;
  logic [15:0] tl_a_user_o;
  logic        tl_a_ready_i;
  logic        tl_d_valid_i;
  logic [2:0]  tl_d_opcode_i;
  logic [7:0]  tl_d_source_i;
  logic [31:0] tl_d_data_i;
  logic        tl_d_error_i;
  logic        tl_d_ready_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tlul_host_bridge #(
    .MAX_OUTSTANDING(2),
    .SOURCE_BASE(8'h00)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .req_i(req_i),
    .gnt_o(gnt_o),
    .addr_i(addr_i),
    .we_i(we_i),
    .wdata_i(wdata_i),
    .be_i(be_i),
    .rvalid_o(rvalid_o),
    .rdata_o(rdata_o),
    .err_o(err_o),
    .tl_a_valid_o(tl_a_valid_o),
    .tl_a_opcode_o(tl_a_opcode_o),
    .tl_a_param_o(tl_a_param_o),
    .tl_a_size_o(tl_a_size_o),
    .tl_a_source_o(tl_a_source_o),
    .tl_a_address_o(tl_a_address_o),
    .tl_a_mask_o(tl_a_mask_o),
    .tl_a_data_o(tl_a_data_o),
    .tl_a_user_o(tl_a_user_o),
    .tl_a_ready_i(tl_a_ready_i),
    .tl_d_valid_i(tl_d_valid_i),
    .tl_d_opcode_i(tl_d_opcode_i),
    .tl_d_source_i(tl_d_source_i),
    .tl_d_data_i(tl_d_data_i),
    .tl_d_error_i(tl_d_error_i),
    .tl_d_ready_o(tl_d_ready_o)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic host(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b);
    req_i = r; we_i = w; addr_i = a; wdata_i = d; be_i = b;
  endtask

  task automatic dbeat(input logic v, input logic [2:0] op,
                       input logic [7:0] src, input logic [31:0] d,
                       input logic e);
    tl_d_valid_i = v; tl_d_opcode_i = op; tl_d_source_i = src;
    tl_d_data_i = d; tl_d_error_i = e;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic exp_src_err;

  initial begin
`ifdef TLUL_HOST_SRCCHK_EN
    exp_src_err = 1'b1;
`else
    exp_src_err = 1'b0;
`endif
    rst_ni = 1'b0;
    tl_a_ready_i = 1'b1;
    host(0, 0, 32'h0, 32'h0, 4'h0);
    dbeat(0, 3'd0, 8'h0, 32'h0, 0);
    #1;
    check("rst_gnt", 32'(gnt_o), 0);
    check("rst_avalid", 32'(tl_a_valid_o), 0);
    check("rst_rvalid", 32'(rvalid_o), 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_err", 32'(err_o), 0);
    check("d_ready", 32'(tl_d_ready_o), 1);
    @(negedge clk);
    rst_ni = 1'b1;

    // single read
    @(negedge clk);
    host(1, 0, 32'h4000_0006, 32'h0, 4'h0);
    #1;
    check("rd_gnt", 32'(gnt_o), 1);
    check("rd_op", 32'(tl_a_opcode_o), 4);
    check("rd_addr", tl_a_address_o, 32'h4000_0004);
    check("rd_mask", 32'(tl_a_mask_o), 32'hF);
    check("rd_src", 32'(tl_a_source_o), 0);
    check("rd_data", tl_a_data_o, 0);
    check("rd_size", 32'(tl_a_size_o), 2);
    check("rd_param", 32'(tl_a_param_o), 0);
    check("rd_user", 32'(tl_a_user_o), 0);
    step();
    @(negedge clk);
    host(0, 0, 32'h0, 32'h0, 4'h0);
    dbeat(1, 3'd1, 8'd0, 32'hDEAD_BEEF, 0);
    step();
    check("rd_rvalid", 32'(rvalid_o), 1);
    check("rd_rdata", rdata_o, 32'hDEAD_BEEF);
    check("rd_err", 32'(err_o), 0);
    @(negedge clk);
    dbeat(0, 3'd0, 8'd0, 32'h0, 0);
    step();
    check("rd_rvalid_drop", 32'(rvalid_o), 0);
    check("rd_rdata_hold", rdata_o, 32'hDEAD_BEEF);

    // partial write
    @(negedge clk);
    host(1, 1, 32'h0000_0010, 32'h1234_5678, 4'b0011);
    #1;
    check("pw_op", 32'(tl_a_opcode_o), 1);
    check("pw_mask", 32'(tl_a_mask_o), 32'h3);
    check("pw_data", tl_a_data_o, 32'h1234_5678);
    check("pw_src", 32'(tl_a_source_o), 1);
    step();
    @(negedge clk);
    host(0, 0, 32'h0, 32'h0, 4'h0);
    dbeat(1, 3'd0, 8'd1, 32'hFFFF_FFFF, 0);
    step();
    check("pw_rvalid", 32'(rvalid_o), 1);
    check("pw_rdata", rdata_o, 0);
    check("pw_err", 32'(err_o), 0);

    // back-pressure with a full write
    @(negedge clk);
    dbeat(0, 3'd0, 8'd0, 32'h0, 0);
    host(1, 1, 32'h0000_0020, 32'hA5A5_A5A5, 4'hF);
    tl_a_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_avalid", 32'(tl_a_valid_o), 1);
      check("bp_gnt", 32'(gnt_o), 0);
      @(negedge clk);
    end
    tl_a_ready_i = 1'b1;
    #1;
    check("bp_op_full", 32'(tl_a_opcode_o), 0);
    check("bp_gnt_rel", 32'(gnt_o), 1);
    check("bp_src0", 32'(tl_a_source_o), 0);
    step();
    @(negedge clk);
    host(1, 0, 32'h0000_0024, 32'h0, 4'h0);
    #1;
    check("full_gnt2", 32'(gnt_o), 1);
    check("full_src1", 32'(tl_a_source_o), 1);
    step();
    @(negedge clk);
    host(1, 0, 32'h0000_0028, 32'h0, 4'h0);
    #1;
    check("full_avalid", 32'(tl_a_valid_o), 0);
    check("full_gnt", 32'(gnt_o), 0);
    step();
    @(negedge clk);
    dbeat(1, 3'd0, 8'd0, 32'h0, 0);
    #1;
    check("full_retire_nognt", 32'(gnt_o), 0);
    step();
    @(negedge clk);
    dbeat(0, 3'd0, 8'd0, 32'h0, 0);
    #1;
    check("free_rvalid", 32'(rvalid_o), 1);
    check("free_gnt", 32'(gnt_o), 1);
    check("free_src_wrap", 32'(tl_a_source_o), 0);
    step();

    // simultaneous grant and retire at one outstanding
    @(negedge clk);
    host(0, 0, 32'h0, 32'h0, 4'h0);
    dbeat(1, 3'd0, 8'd1, 32'h0, 0);
    step();
    @(negedge clk);
    host(1, 0, 32'h0000_0030, 32'h0, 4'h0);
    dbeat(1, 3'd1, 8'd0, 32'h1111_1111, 0);
    #1;
    check("sim1_gnt", 32'(gnt_o), 1);
    check("sim1_src", 32'(tl_a_source_o), 1);
    step();
    check("sim1_rdata", rdata_o, 32'h1111_1111);
    @(negedge clk);
    dbeat(1, 3'd1, 8'd1, 32'h2222_2222, 0);
    #1;
    check("sim2_gnt", 32'(gnt_o), 1);
    check("sim2_src", 32'(tl_a_source_o), 0);
    step();
    check("sim2_rdata", rdata_o, 32'h2222_2222);
    @(negedge clk);
    dbeat(1, 3'd1, 8'd0, 32'h3333_3333, 0);
    #1;
    check("sim3_gnt", 32'(gnt_o), 1);
    check("sim3_src", 32'(tl_a_source_o), 1);
    step();
    check("sim3_err", 32'(err_o), 0);
    @(negedge clk);
    dbeat(0, 3'd0, 8'd0, 32'h0, 0);
    #1;
    check("cnt1_gnt", 32'(gnt_o), 1);
    check("cnt1_src", 32'(tl_a_source_o), 0);
    step();
    @(negedge clk);
    #1;
    check("cnt2_avalid", 32'(tl_a_valid_o), 0);

    // error responses
    host(0, 0, 32'h0, 32'h0, 4'h0);
    dbeat(1, 3'd1, 8'd1, 32'h0000_0055, 1);
    step();
    check("derr_rvalid", 32'(rvalid_o), 1);
    check("derr_err", 32'(err_o), 1);
    check("derr_rdata", rdata_o, 32'h55);
    @(negedge clk);
    dbeat(1, 3'd2, 8'd0, 32'h0000_0066, 0);
    step();
    check("dop_err", 32'(err_o), 1);
    check("dop_rdata", rdata_o, 0);
    @(negedge clk);
    dbeat(0, 3'd0, 8'd0, 32'h0, 0);
    step();
    check("err_hold", 32'(err_o), 1);
    check("err_rvalid_drop", 32'(rvalid_o), 0);
    @(negedge clk);
    dbeat(1, 3'd0, 8'd1, 32'h0, 0);
    step();
    check("stray_rvalid", 32'(rvalid_o), 1);
    check("stray_err", 32'(err_o), 1);
    @(negedge clk);
    dbeat(0, 3'd0, 8'd0, 32'h0, 0);
    host(1, 0, 32'h0000_0040, 32'h0, 4'h0);
    #1;
    check("stray_gnt", 32'(gnt_o), 1);
    check("stray_src", 32'(tl_a_source_o), 1);
    step();
    @(negedge clk);
    #1;
    check("stray_gnt2", 32'(gnt_o), 1);
    step();
    @(negedge clk);
    #1;
    check("stray_full", 32'(tl_a_valid_o), 0);

    // reset mid-operation
    dbeat(1, 3'd1, 8'd1, 32'h0000_0077, 1);
    step();
    check("pre_rst_rdata", rdata_o, 32'h77);
    check("pre_rst_err", 32'(err_o), 1);
    @(negedge clk);
    dbeat(0, 3'd0, 8'd0, 32'h0, 0);
    #1;
    check("pre_rst_gnt", 32'(gnt_o), 1);
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    check("mrst_avalid", 32'(tl_a_valid_o), 0);
    check("mrst_gnt", 32'(gnt_o), 0);
    check("mrst_rdata", rdata_o, 0);
    check("mrst_err", 32'(err_o), 0);
    @(negedge clk);
    host(0, 0, 32'h0, 32'h0, 4'h0);
    rst_ni = 1'b1;
    @(negedge clk);
    dbeat(1, 3'd1, 8'd0, 32'h0000_0099, 0);
    step();
    check("post_rst_stray_rv", 32'(rvalid_o), 1);
    check("post_rst_stray_err", 32'(err_o), 1);
    @(negedge clk);
    dbeat(0, 3'd0, 8'd0, 32'h0, 0);
    host(1, 0, 32'h0000_0050, 32'h0, 4'h0);
    #1;
    check("post_rst_src", 32'(tl_a_source_o), 0);
    step();
    @(negedge clk);
    host(0, 0, 32'h0, 32'h0, 4'h0);
    dbeat(1, 3'd1, 8'd1, 32'h0000_00AB, 0);
    step();
    check("srcchk_rdata", rdata_o, 32'hAB);
    check("srcchk_err", 32'(err_o), 32'(exp_src_err));
    @(negedge clk);
    dbeat(0, 3'd0, 8'd0, 32'h0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tlul_host_bridge.md
Name: tlul_host_bridge

Overview:
- Initiator-side TL-UL bridge: turns a simple req/gnt/rvalid host port (core LSU, debug master, DMA) into TL-UL A-channel requests and retires D-channel responses.
- Tracks outstanding transactions, assigns rotating a_source IDs and reports read data and errors back to the host.
- Sits between a host master and the TL-UL crossbar. All widths come from top_pkg: TL_AW=32, TL_DW=32, TL_AIW=8, TL_DIW=1, TL_AUW=16, TL_DUW=16, TL_DBW=4, TL_SZW=2.

Parameters:
- MAX_OUTSTANDING, 2, max in-flight requests; range 1..16, power of two; must not exceed 2**TL_AIW.
- SOURCE_BASE, 0, value added to the rotating ID to form a_source; width TL_AIW.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- req_i  in  1  host request valid.
- gnt_o  out  1  host request accepted this cycle.
- addr_i  in  TL_AW  byte address; bits [1:0] are forced to 0 on a_address.
- we_i  in  1  1 = write, 0 = read.
- wdata_i  in  TL_DW  write data.
- be_i  in  TL_DBW  byte enables.
- rvalid_o  out  1  response valid, one cycle per granted request.
- rdata_o  out  TL_DW  read data; 0 for writes.
- err_o  out  1  response error, qualified by rvalid_o.
- tl_a_valid_o  out  1  A-channel valid.
- tl_a_opcode_o  out  3  0 = PutFullData, 1 = PutPartialData, 4 = Get.
- tl_a_param_o  out  3  tied to 0.
- tl_a_size_o  out  TL_SZW  tied to 2 (4 bytes).
- tl_a_source_o  out  TL_AIW  transaction ID.
- tl_a_address_o  out  TL_AW  word-aligned address.
- tl_a_mask_o  out  TL_DBW  byte mask; all ones for Get.
- tl_a_data_o  out  TL_DW  write data; 0 for Get.
- tl_a_user_o  out  TL_AUW  tied to 0.
- tl_a_ready_i  in  1  A-channel ready.
- tl_d_valid_i  in  1  D-channel valid.
- tl_d_opcode_i  in  3  0 = AccessAck, 1 = AccessAckData.
- tl_d_source_i  in  TL_AIW  response ID.
- tl_d_data_i  in  TL_DW  response data.
- tl_d_error_i  in  1  responder error.
- tl_d_ready_o  out  1  D-channel ready; constant 1.

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, tl_a_valid_o=0; outstanding counter, issue pointer and retire pointer all 0. Reset is asynchronous.
- Capacity: space = (outstanding < MAX_OUTSTANDING).
- A channel (combinational): tl_a_valid_o = req_i & space; A fields are driven straight from the host inputs.
- Grant: gnt_o = tl_a_valid_o & tl_a_ready_i. The host must hold req_i and its fields stable until granted.
- Opcode selection: Get when !we_i; PutFullData when we_i & be_i==4'hF; PutPartialData otherwise.
- Source ID: tl_a_source_o = SOURCE_BASE + issue_ptr. issue_ptr wraps modulo MAX_OUTSTANDING and advances on gnt.
- Retire: D handshake is tl_d_valid_i, since d_ready is always 1.
- Response registers: on a D handshake, the following are registered for exactly one cycle (latency 1 cycle after the D beat). With no D beat, rvalid_o=0 and rdata_o/err_o hold their previous values.
  - rvalid_o = 1.
  - rdata_o = d_data if opcode==AccessAckData, else 0.
  - err_o = d_error | opcode not in {0,1}.
- Pointers on retire: retire_ptr advances, wrapping modulo MAX_OUTSTANDING.
- Outstanding counter: +1 on gnt, -1 on D beat, unchanged when both occur in the same cycle.
  - At full, a simultaneous retire does not enable a grant in the same cycle; space uses the registered count.
- Stray response: a D beat with outstanding==0 gives rvalid_o=1, err_o=1, and the counter stays 0 (no underflow).
- Ordering: responses are retired in issue order.
- Reset mid-operation clears all state; in-flight responses arriving afterwards are treated as stray responses.

Optional Feature:
- Macro: TLUL_HOST_SRCCHK_EN.
- When defined: a D beat whose d_source != SOURCE_BASE + retire_ptr forces err_o=1 on that response. A sticky internal flag is set; it clears only on reset.
- When undefined: d_source is ignored; err_o depends only on d_error and d_opcode.

Test Plan:
- Single read: addr_i=0x4000_0006, we_i=0, ready=1.
  - A channel: gnt_o=1 that cycle; opcode=4, address=0x4000_0004, mask=4'hF, source=0.
  - D beat AccessAckData, data=0xDEADBEEF: next cycle rvalid_o=1, rdata_o=0xDEADBEEF, err_o=0.
- Partial write: we_i=1, be_i=4'b0011, wdata=0x1234_5678 -> opcode=1, mask=0011, data=0x12345678. AccessAck gives rvalid_o=1, rdata_o=0.
- Back-pressure and full:
  - tl_a_ready_i=0 for 3 cycles -> gnt_o=0 while tl_a_valid_o=1.
  - With MAX_OUTSTANDING=2 and two grants and no D beats, the third request sees tl_a_valid_o=0.
  - A D beat frees one slot; the grant occurs the following cycle with source=0 after wrap.
- Simultaneous grant and retire at outstanding=1 -> count stays 1; sources continue 1, 0, 1.
- Errors:
  - d_error=1 gives err_o=1.
  - d_opcode=2 gives err_o=1.
  - A stray D beat at outstanding=0 gives rvalid_o=1, err_o=1, count=0.
- Reset mid-operation: assert rst_ni low with 2 outstanding -> outputs go to 0 immediately. With TLUL_HOST_SRCCHK_EN defined, a response with d_source=1 when 0 is expected gives err_o=1.
